// File: rtl/sram_arbiter_if.sv
// Request/response bus between the two requesters and the SRAM arbiter.
// Two-bit fields carry one bit per requester; 64-bit fields carry one 32-bit lane per requester.
interface sram_arbiter_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_addr;
    logic [1:0]  req_we;
    logic [7:0]  req_be;
    logic [63:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [63:0] rsp_rdata;
    logic [1:0]  rsp_err;

    modport master (
        output req_valid, req_addr, req_we, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM macro between two requesters.
// Pipeline: accept/issue (E0) -> SRAM sample (E1) -> response register (E2).
module sram_arbiter #(
    parameter int unsigned ADDR_W    = 15,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RSTN,
    sram_arbiter_if.slave     bus,
    output logic              CEB,
    output logic              OEB,
    output logic              GWEB,
    output logic              BWEB,
    output logic [3:0]        BWB,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       DIN,
    input  logic [31:0]       DOUT
);
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_NOP, OP_ERR} op_e;

    // Upper address bits that must match the region base; the region is size-aligned.
    localparam logic [31:0] REGION_MASK = ~((32'd4 << ADDR_W) - 32'd1);

    logic        last_q, last_d;
    logic [1:0]  grant;
    logic        accept;
    logic        sel;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_be;
    logic        sel_we;
    op_e         sel_op;

    logic              iss_valid_q, iss_valid_d;
    logic              iss_port_q, iss_port_d;
    op_e               iss_op_q, iss_op_d;
    logic              ceb_q, ceb_d;
    logic              gweb_q, gweb_d;
    logic              bweb_q, bweb_d;
    logic [3:0]        bwb_q, bwb_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       din_q, din_d;

    logic rd_valid_q;
    logic rd_port_q;
    op_e  rd_op_q;

    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [1:0]  rsp_err_q, rsp_err_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant = 2'b00;
        case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        bus.req_ready = RSTN ? grant : 2'b00;
    end

    assign accept = |bus.req_ready;
    assign sel    = bus.req_ready[1];

    always_comb begin
        sel_addr  = sel ? bus.req_addr[63:32]  : bus.req_addr[31:0];
        sel_wdata = sel ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
        sel_be    = sel ? bus.req_be[7:4]      : bus.req_be[3:0];
        sel_we    = sel ? bus.req_we[1]        : bus.req_we[0];
        if ((sel_addr & REGION_MASK) != (BASE_ADDR & REGION_MASK)) begin
            sel_op = OP_ERR;
        end else if (!sel_we) begin
            sel_op = OP_READ;
        end else if (sel_be == 4'h0) begin
            sel_op = OP_NOP;
        end else begin
            sel_op = OP_WRITE;
        end
    end

    // Strobes idle high every cycle without a real access; A/DIN simply hold.
    always_comb begin
        last_d      = last_q;
        iss_valid_d = accept;
        iss_port_d  = sel;
        iss_op_d    = sel_op;
        ceb_d       = 1'b1;
        gweb_d      = 1'b1;
        bweb_d      = 1'b1;
        bwb_d       = 4'hF;
        a_d         = a_q;
        din_d       = din_q;
        if (accept) begin
            last_d = sel;
            a_d    = sel_addr[ADDR_W+1:2];
            din_d  = sel_wdata;
            case (sel_op)
                OP_READ: begin
                    ceb_d = 1'b0;
                    bwb_d = 4'h0;
                end
                OP_WRITE: begin
                    ceb_d = 1'b0;
                    if (sel_be == 4'hF) begin
                        gweb_d = 1'b0;
                    end else begin
                        bweb_d = 1'b0;
                        bwb_d  = ~sel_be;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid_d = 2'b00;
        rsp_err_d   = 2'b00;
        rsp_rdata_d = 64'h0;
        if (rd_valid_q) begin
            rsp_valid_d[rd_port_q] = 1'b1;
            if (rd_op_q == OP_ERR) begin
                rsp_err_d[rd_port_q] = 1'b1;
            end
            if (rd_op_q == OP_READ) begin
                rsp_rdata_d = rd_port_q ? {DOUT, 32'h0} : {32'h0, DOUT};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            last_q      <= 1'b1;
            iss_valid_q <= 1'b0;
            iss_port_q  <= 1'b0;
            iss_op_q    <= OP_NOP;
            ceb_q       <= 1'b1;
            gweb_q      <= 1'b1;
            bweb_q      <= 1'b1;
            bwb_q       <= 4'hF;
            a_q         <= '0;
            din_q       <= 32'h0;
            rd_valid_q  <= 1'b0;
            rd_port_q   <= 1'b0;
            rd_op_q     <= OP_NOP;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 2'b00;
            rsp_rdata_q <= 64'h0;
        end else begin
            last_q      <= last_d;
            iss_valid_q <= iss_valid_d;
            iss_port_q  <= iss_port_d;
            iss_op_q    <= iss_op_d;
            ceb_q       <= ceb_d;
            gweb_q      <= gweb_d;
            bweb_q      <= bweb_d;
            bwb_q       <= bwb_d;
            a_q         <= a_d;
            din_q       <= din_d;
            rd_valid_q  <= iss_valid_q;
            rd_port_q   <= iss_port_q;
            rd_op_q     <= iss_op_q;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign CEB  = ceb_q;
    assign OEB  = 1'b0;
    assign GWEB = gweb_q;
    assign BWEB = bweb_q;
    assign BWB  = bwb_q;
    assign A    = a_q;
    assign DIN  = din_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
endmodule
